// File: rtl/uart_rx_if.sv
// uart_rx_if: line, tick and host-side result signals of the UART receiver
interface uart_rx_if;
  logic       bclk_rx;
  logic       p_sel;
  logic       rx;
  logic [7:0] d_out;
  logic       rx_done;
  logic       parity_err;
  logic       frame_err;
  logic       busy;
  modport master (output bclk_rx, p_sel, rx, input d_out, rx_done, parity_err, frame_err, busy);
  modport slave  (input bclk_rx, p_sel, rx, output d_out, rx_done, parity_err, frame_err, busy);
endinterface

// File: rtl/uart_rx.sv
// uart_rx: oversampled UART receiver, frame = start, d[7..0] MSB first, parity, stop
module uart_rx #(
  parameter int OVERSAMPLE = 16
) (
  input logic     clk,
  input logic     reset,
  uart_rx_if.slave bus
);
  localparam int TW = $clog2(OVERSAMPLE);
  // the IDLE tick that sees the falling edge counts as the first start-bit tick
  localparam logic [TW-1:0] T_MID = TW'(OVERSAMPLE / 2 - 2);
  localparam logic [TW-1:0] T_BIT = TW'(OVERSAMPLE - 1);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, BREAK} state_t;

  state_t          state, state_nx;
  logic            rx_m, rx_s;
  logic [TW-1:0]   tick_cnt;
  logic [2:0]      bit_cnt;
  logic [7:0]      shreg;
  logic            pbit;
  logic            mid, samp;

  assign mid      = bus.bclk_rx && tick_cnt == T_MID;
  assign samp     = bus.bclk_rx && tick_cnt == T_BIT;
  assign bus.busy = state != IDLE;

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    state_nx = (bus.bclk_rx && !rx_s) ? START : IDLE;
      START:   state_nx = !mid ? START : (rx_s ? IDLE : DATA);
      DATA:    state_nx = (samp && bit_cnt == 3'd7) ? PARITY : DATA;
      PARITY:  state_nx = samp ? STOP : PARITY;
      STOP:    state_nx = !samp ? STOP : (rx_s ? IDLE : BREAK);
      BREAK:   state_nx = rx_s ? IDLE : BREAK;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset)
    if (!reset) state <= IDLE;
    else        state <= state_nx;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rx_m           <= 1'b1;
      rx_s           <= 1'b1;
      tick_cnt       <= '0;
      bit_cnt        <= '0;
      shreg          <= '0;
      pbit           <= 1'b0;
      bus.d_out      <= '0;
      bus.rx_done    <= 1'b0;
      bus.parity_err <= 1'b0;
      bus.frame_err  <= 1'b0;
    end else begin
      rx_m        <= bus.rx;
      rx_s        <= rx_m;
      bus.rx_done <= state == STOP && samp;
      if (bus.bclk_rx)
        tick_cnt <= (state == IDLE || (state == START && mid) || tick_cnt == T_BIT) ? '0 : tick_cnt + 1'b1;
      if (state == START && mid) bit_cnt <= '0;
      if (state == DATA && samp) begin
        shreg   <= {shreg[6:0], rx_s};
        bit_cnt <= bit_cnt + 3'd1;
      end
      if (state == PARITY && samp) pbit <= rx_s;
      if (state == STOP && samp) begin
        bus.d_out      <= shreg;
        bus.parity_err <= pbit != (bus.p_sel ? ^shreg : ~^shreg);
        bus.frame_err  <= ~rx_s;
      end
    end
  end
endmodule
